// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS control FSM
// Latency: n/a (constants and types only)
// Backpressure: n/a
// Contents: 4-bit state encodings, opcode/funct constants, ALU op codes,
//           datapath mux select codes.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose: bundle between the control FSM and the multi-cycle datapath
// Latency: n/a (wires only)
// Backpressure: mem_ready stretches the controller's memory states
// Ports: master = controller (drives selects/enables), slave = datapath.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;
  logic [2:0] alu_oper;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       ovf_trap;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, overflow, mem_ready,
    output alu_oper, alu_src_a, alu_src_b, pc_en, pc_source, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           ovf_trap, illegal, state
  );

  modport slave (
    output op, funct, zero, overflow, mem_ready,
    input  alu_oper, alu_src_a, alu_src_b, pc_en, pc_source, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           ovf_trap, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// Purpose: R-type funct decoder shared by DECODE legality and EXEC ALU op
// Latency: combinational
// Backpressure: none
// Ports: funct in; alu_oper, funct_valid, is_addsub out.
module alu_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_oper,
  output logic       funct_valid,
  output logic       is_addsub
);

  always_comb begin
    alu_oper    = ALU_AND;
    funct_valid = 1'b1;
    is_addsub   = 1'b0;
    case (funct)
      FN_ADD: begin alu_oper = ALU_ADD; is_addsub = 1'b1; end
      FN_SUB: begin alu_oper = ALU_SUB; is_addsub = 1'b1; end
      FN_AND: alu_oper = ALU_AND;
      FN_OR:  alu_oper = ALU_OR;
      FN_SLT: alu_oper = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle MIPS control FSM (fetch/decode/execute/mem/writeback)
// Latency: 3-5 cycles per instruction with mem_ready high; outputs decode current state
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready (when MEM_WAIT_EN=1)
// Ports: clk, rst (sync, active-high), ctl = master side of multicycle_ctrl_if.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  ctl
);

  state_t     state_q;
  logic       ovf_q;
  logic       mem_rdy;
  logic [2:0] dec_oper;
  logic       funct_valid;
  logic       is_addsub;

  assign mem_rdy = MEM_WAIT_EN ? ctl.mem_ready : 1'b1;

  alu_dec u_alu_dec (
    .funct       (ctl.funct),
    .alu_oper    (dec_oper),
    .funct_valid (funct_valid),
    .is_addsub   (is_addsub)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ovf_q <= 1'b0;
          if (mem_rdy) state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (ctl.op)
            OP_LW, OP_SW:   state_q <= S_MEMADR;
            OP_RTYPE:       state_q <= funct_valid ? S_EXEC : S_ILLEGAL;
            OP_BEQ, OP_BNE: state_q <= S_BRANCH;
            OP_J:           state_q <= S_JUMP;
            OP_ADDI:        state_q <= S_IEXEC;
            default:        state_q <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: state_q <= (ctl.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_rdy) state_q <= S_MEMWB;
        S_MEMWR:  if (mem_rdy) state_q <= S_FETCH;
        S_EXEC: begin
          // only add/sub can trap; logic ops and slt never overflow
          ovf_q   <= is_addsub & ctl.overflow;
          state_q <= S_RWB;
        end
        S_IEXEC: begin
          ovf_q   <= ctl.overflow;
          state_q <= S_IWB;
        end
        // single-cycle states and unused encodings 13-15 return to FETCH
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the current state; rst forces everything low so an
  // aborted instruction never writes in the reset cycle.
  always_comb begin
    ctl.alu_oper   = ALU_AND;
    ctl.alu_src_a  = 1'b0;
    ctl.alu_src_b  = SRCB_REG;
    ctl.pc_en      = 1'b0;
    ctl.pc_source  = PCS_ALU;
    ctl.iord       = 1'b0;
    ctl.mem_read   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.ir_write   = 1'b0;
    ctl.reg_dst    = 1'b0;
    ctl.mem_to_reg = 1'b0;
    ctl.reg_write  = 1'b0;
    ctl.ovf_trap   = 1'b0;
    ctl.illegal    = 1'b0;
    ctl.state      = 4'd0;
    if (!rst) begin
      ctl.state = state_q;
      case (state_q)
        S_FETCH: begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = SRCB_FOUR;
          ctl.alu_oper  = ALU_ADD;
          // PC+4 and IR load happen together on the cycle memory delivers
          ctl.ir_write  = mem_rdy;
          ctl.pc_en     = mem_rdy;
        end
        S_DECODE: begin
          ctl.alu_src_b = SRCB_IMM_SH;
          ctl.alu_oper  = ALU_ADD;
        end
        S_MEMADR, S_IEXEC: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_IMM;
          ctl.alu_oper  = ALU_ADD;
        end
        S_MEMRD: begin
          ctl.mem_read = 1'b1;
          ctl.iord     = 1'b1;
        end
        S_MEMWB: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctl.mem_write = 1'b1;
          ctl.iord      = 1'b1;
        end
        S_EXEC: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_oper  = dec_oper;
        end
        S_RWB: begin
          ctl.reg_dst   = 1'b1;
          ctl.reg_write = ~ovf_q;
          ctl.ovf_trap  = ovf_q;
        end
        S_IWB: begin
          ctl.reg_write = ~ovf_q;
          ctl.ovf_trap  = ovf_q;
        end
        S_BRANCH: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_oper  = ALU_SUB;
          ctl.pc_source = PCS_ALUOUT;
          ctl.pc_en     = (ctl.op == OP_BEQ) ?  ctl.zero :
                          (ctl.op == OP_BNE) ? ~ctl.zero : 1'b0;
        end
        S_JUMP: begin
          ctl.pc_en     = 1'b1;
          ctl.pc_source = PCS_JUMP;
        end
        S_ILLEGAL: ctl.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control FSM for the multi-cycle MIPS datapath. It is the driving end of the ALU interface: it issues the 3-bit ALU operation code and consumes the ALU's zero and overflow flags. It sequences fetch, decode, execute, memory and writeback, and drives every datapath mux select and write enable. A memory-ready handshake stretches the memory states.

Parameters:
MEM_WAIT_EN, 1, when 1 the memory states hold until mem_ready; when 0 mem_ready is treated as constant 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
op  in  6  instruction opcode from IR[31:26]
funct  in  6  instruction funct from IR[5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU signed-overflow flag
mem_ready  in  1  memory completes the current read/write this cycle
alu_oper  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
pc_en  out  1  PC load enable, branch condition already resolved
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
iord  out  1  0 PC address, 1 ALUOut address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
reg_write  out  1  register file write enable
ovf_trap  out  1  one-cycle pulse: arithmetic overflow, write suppressed
illegal  out  1  one-cycle pulse: unsupported op/funct
state  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- While rst=1: the state register loads FETCH on the next clk edge. In that same cycle, pc_en, mem_read, mem_write, ir_write, reg_write, ovf_trap and illegal are forced to 0, and every other output is 0.
- Reset mid-instruction aborts the instruction. No write enable is asserted in the reset cycle.
- Outputs are Moore (decoded from state), with these exceptions: pc_en in FETCH, ir_write and the branch condition.
- Unlisted outputs in a state are 0.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, ILLEGAL 12.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_oper=010, pc_source=00.
  - ir_write=pc_en=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_oper=010 (branch target into ALUOut).
  - Next state: lw/sw (100011/101011) -> MEMADR; R-type (000000) with a valid funct -> EXEC; beq/bne (000100/000101) -> BRANCH; j (000010) -> JUMP; addi (001000) -> IEXEC; otherwise -> ILLEGAL.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_oper=010. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready, then -> MEMWB.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready, then -> FETCH. mem_write stays high for every hold cycle.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00.
  - alu_oper from funct: 100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111.
  - ovf_q<=overflow when funct is add or sub, else 0. -> RWB.
- RWB: reg_dst=1, mem_to_reg=0, reg_write=~ovf_q, ovf_trap=ovf_q. -> FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_oper=010, ovf_q<=overflow. -> IWB.
- IWB: reg_dst=0, mem_to_reg=0, reg_write=~ovf_q, ovf_trap=ovf_q. -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_oper=110, pc_source=01.
  - pc_en = zero for beq, ~zero for bne. -> FETCH.
- JUMP: pc_en=1, pc_source=10. -> FETCH.
- ILLEGAL: illegal=1, no writes. -> FETCH.
- ovf_q is internal. It resets to 0 and is cleared in FETCH.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Unused encodings 13-15 -> FETCH next cycle, with no writes asserted.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the 4-bit state encodings;
  - the opcode and funct constants;
  - the ALU op encodings (AND 000, OR 001, ADD 010, SUB 110, SLT 111).
- One combinational sub-module, alu_dec: funct -> {alu_oper, funct_valid, is_addsub}. It is used by both the DECODE legality check and EXEC.

Test Plan:
- lw (op 100011) with mem_ready low 2 cycles in FETCH and 1 cycle in MEMRD -> state trace 0,0,0,1,2,3,3,4,0. ir_write pulses once. reg_write=1 only in MEMWB with mem_to_reg=1.
- R-type sub (funct 100010) with overflow=1 in EXEC -> alu_oper=110 in EXEC. In RWB: reg_write=0, ovf_trap=1 for exactly one cycle. Next instruction fetches normally.
- beq with zero=1, then bne with zero=1 -> pc_en=1 in BRANCH for beq, 0 for bne. pc_source=01 in both.
- Unknown op 111111, then R-type with funct 000111 -> each reaches ILLEGAL: illegal pulses 1 cycle, no reg_write or mem_write, then FETCH.
- rst=1 asserted in MEMWR with mem_ready=0 -> mem_write=0 in the reset cycle. state=0 the following cycle. ovf_q cleared.
- MEM_WAIT_EN=0 with mem_ready tied 0 -> sw completes in 4 cycles: trace 0,1,2,5,0.
